// File: rtl/cdb_issue_arbiter.sv
// Issue-select for the int/mem/mult/div reservation stations: one grant per cycle,
// CDB write-slot reservation, divider occupancy and int starvation protection.
module cdb_issue_arbiter #(
  parameter int INT_LAT    = 1,
  parameter int MEM_LAT    = 2,
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_int_rdy,
  input  logic               i_mem_rdy,
  input  logic               i_mult_rdy,
  input  logic               i_div_rdy,
  output logic               o_issue_done_int,
  output logic               o_issue_done_mem,
  output logic               o_issue_done_mult,
  output logic               o_issue_done_div,
  output logic               o_div_busy,
  output logic [DIV_LAT-1:0] o_cdb_busy,
  output logic               o_starve
);

  localparam int CW   = $clog2(DIV_LAT + 1);
  localparam int SW   = $clog2(STARVE_LIM + 1);
  localparam int NCLS = 4;

  // Class index order doubles as priority order: 3 (div) is highest.
  function automatic int lat_of(input int cls);
    case (cls)
      0:       return INT_LAT;
      1:       return MEM_LAT;
      2:       return MULT_LAT;
      default: return DIV_LAT;
    endcase
  endfunction

  logic [DIV_LAT-1:0]            r_slots;
  logic [CW-1:0]                 r_div_cnt;
  logic [SW-1:0]                 r_starve_cnt;

  logic [DIV_LAT-1:0]            w_shift;
  logic [DIV_LAT-1:0]            w_slots_next;
  logic [NCLS-1:0][DIV_LAT-1:0]  w_set;
  logic [NCLS-1:0]               w_rdy;
  logic [NCLS-1:0]               w_class_ok;
  logic [NCLS-1:0]               w_elig;
  logic [NCLS-1:0]               w_grant;
  logic                          w_div_free;
  logic                          w_starve;
  logic                          w_block;

  assign w_rdy      = {i_div_rdy, i_mult_rdy, i_mem_rdy, i_int_rdy};
  assign w_block    = i_rst | i_flush;
  assign w_starve   = (r_starve_cnt == SW'(STARVE_LIM));
  // Slot checks look at the vector as it will be after this edge's shift, so a
  // grant now that lands L cycles out tests the same bit it is about to claim.
  assign w_shift    = r_slots >> 1;
  // The divider frees up on the edge where its count reaches zero.
  assign w_div_free = (r_div_cnt <= CW'(1));

  for (genvar gi = 0; gi < NCLS; gi++) begin : g_cls
    localparam int L = lat_of(gi);
    if (gi == 0) begin : g_int
      assign w_class_ok[gi] = 1'b1;
    end else if (gi == NCLS - 1) begin : g_div
      assign w_class_ok[gi] = ~w_starve & w_div_free;
    end else begin : g_mid
      assign w_class_ok[gi] = ~w_starve;
    end
    assign w_elig[gi] = w_rdy[gi] & ~w_shift[L-1] & ~w_block & w_class_ok[gi];
    assign w_set[gi]  = w_grant[gi] ? (DIV_LAT'(1) << (L - 1)) : '0;
  end

  always_comb begin
    w_grant = '0;
    if (w_elig[3])      w_grant[3] = 1'b1;
    else if (w_elig[2]) w_grant[2] = 1'b1;
    else if (w_elig[1]) w_grant[1] = 1'b1;
    else if (w_elig[0]) w_grant[0] = 1'b1;
  end

  always_comb begin
    w_slots_next = w_shift;
    for (int c = 0; c < NCLS; c++) begin
      w_slots_next = w_slots_next | w_set[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_block) begin
      r_slots      <= '0;
      r_div_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_slots <= w_slots_next;
      if (w_grant[3])
        r_div_cnt <= CW'(DIV_LAT);
      else if (r_div_cnt != '0)
        r_div_cnt <= r_div_cnt - CW'(1);
      if (!i_int_rdy || w_grant[0])
        r_starve_cnt <= '0;
      else if (!w_starve)
        r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  assign o_issue_done_int  = w_grant[0];
  assign o_issue_done_mem  = w_grant[1];
  assign o_issue_done_mult = w_grant[2];
  assign o_issue_done_div  = w_grant[3];
  // State is only cleared at the first reset edge, so mask it while reset is held.
  assign o_div_busy        = ~i_rst & (r_div_cnt != '0);
  assign o_cdb_busy        = i_rst ? '0 : r_slots;
  assign o_starve          = ~i_rst & w_starve;

endmodule
